// File: rtl/decoder_sweep_checker.sv
// Exhaustive sweep checker for a 3-to-8 decoder. It generates all 16 in/en
// vectors, compares the decoder response against the one-hot code, and reports
// a saturating mismatch count and the index of the first mismatch.
module decoder_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 1,  // legal 1..15
    parameter int unsigned ERR_CNT_W     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    output logic [2:0]           o_in,
    output logic                 o_en,
    input  logic [7:0]           i_out,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    output logic [3:0]           o_first_err_idx,
    output logic [3:0]           o_vec_idx
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Settle counter counts down to zero; zero marks the compare edge.
    localparam logic [3:0] SettleReload = 4'(SETTLE_CYCLES - 1);
    localparam logic [ERR_CNT_W-1:0] ErrMax = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ErrOne = ERR_CNT_W'(1);

    state_e                 state_q, state_d;
    logic [3:0]             vec_q, vec_d;
    logic [3:0]             settle_q, settle_d;
    logic [ERR_CNT_W-1:0]   err_q, err_d;
    logic [3:0]             first_q, first_d;
    logic [7:0]             expected;
    logic                   mismatch;

    // Reference code for the vector currently driven; disabled half expects all zeros.
    always_comb begin
        expected = 8'h00;
        if (!vec_q[3]) begin
            expected = 8'h01 << vec_q[2:0];
        end
        mismatch = (i_out != expected);
    end

    // Next-state logic for the sweep FSM, vector index, settle timer and error capture.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        first_d  = first_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (i_start) begin
                    state_d  = StRun;
                    vec_d    = 4'd0;
                    settle_d = SettleReload;
                    err_d    = '0;
                    first_d  = 4'd0;
                end
            end
            StRun: begin
                if (settle_q != 4'd0) begin
                    settle_d = settle_q - 4'd1;
                end else begin
                    if (mismatch) begin
                        if (err_q != ErrMax) begin
                            err_d = err_q + ErrOne;
                        end
                        if (err_q == '0) begin
                            first_d = vec_q;
                        end
                    end
                    if (vec_q == 4'd15) begin
                        state_d = StDone;
                    end else begin
                        vec_d    = vec_q + 4'd1;
                        settle_d = SettleReload;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset discards partial results.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            vec_q    <= 4'd0;
            settle_q <= 4'd0;
            err_q    <= '0;
            first_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            first_q  <= first_d;
        end
    end

    // Outputs: the vector is only driven while running, otherwise the decoder sees en=0/in=0.
    always_comb begin
        o_busy          = (state_q == StRun);
        o_done          = (state_q == StDone);
        o_pass          = o_done && (err_q == '0);
        o_en            = o_busy && !vec_q[3];
        o_in            = o_busy ? vec_q[2:0] : 3'd0;
        o_err_cnt       = err_q;
        o_first_err_idx = first_q;
        o_vec_idx       = vec_q;
    end

endmodule

// File: tb/tb_decoder_sweep_checker.sv
// Bench for decoder_sweep_checker: one instance at S=1 and one at S=3, each
// closed around a behavioural decoder model with selectable faults.
module tb_decoder_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start3;
    logic [2:0] in1, in3;
    logic       en1, en3;
    logic [7:0] out1, out3;
    logic       busy1, done1, pass1, busy3, done3, pass3;
    logic [3:0] err1, err3, first1, first3, vidx1, vidx3;

    int checks = 0;
    int errors = 0;

    // Decoder fault modes: 0 golden, 1 out[5] stuck-0, 2 all ones, 3 random xor mask, 4 out[2] stuck-0
    int         mode1, mode3;
    logic [7:0] mask [16];

    always #5 clk = ~clk;

    decoder_sweep_checker #(.SETTLE_CYCLES(1), .ERR_CNT_W(4)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .o_in(in1), .o_en(en1),
        .i_out(out1), .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_cnt(err1),
        .o_first_err_idx(first1), .o_vec_idx(vidx1)
    );

    decoder_sweep_checker #(.SETTLE_CYCLES(3), .ERR_CNT_W(4)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .o_in(in3), .o_en(en3),
        .i_out(out3), .o_busy(busy3), .o_done(done3), .o_pass(pass3), .o_err_cnt(err3),
        .o_first_err_idx(first3), .o_vec_idx(vidx3)
    );

    function automatic logic [7:0] decode(input logic en, input logic [2:0] in, input int mode,
                                          input logic [7:0] m);
        logic [7:0] g;
        g = en ? (8'h01 << in) : 8'h00;
        case (mode)
            1:       return g & 8'hDF;
            2:       return 8'hFF;
            3:       return g ^ m;
            4:       return g & 8'hFB;
            default: return g;
        endcase
    endfunction

    always_comb begin
        out1 = decode(en1, in1, mode1, mask[{~en1, in1}]);
        out3 = decode(en3, in3, mode3, 8'h00);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start on dut1 and walk its 16 vectors, checking the driven sequence.
    task automatic sweep1();
        logic [3:0] kv;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            kv = 4'(k);
            chk("s1_en", 32'(en1), 32'(k < 8));
            chk("s1_in", 32'(in1), 32'(k % 8));
            chk("s1_busy", 32'(busy1), 32'd1);
            chk("s1_vidx", 32'(vidx1), 32'(kv));
            tick();
        end
        chk("s1_end_busy", 32'(busy1), 32'd0);
        chk("s1_end_done", 32'(done1), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nerr;
        int         firstk;
        logic [3:0] sat;

        mode1 = 0;
        mode3 = 0;
        for (int k = 0; k < 16; k++) mask[k] = 8'h00;

        // Reset held with start asserted
        rst_n  = 1'b0;
        start1 = 1'b1;
        start3 = 1'b1;
        #1;
        repeat (3) tick();
        chk("rst_in", 32'(in1), 32'd0);
        chk("rst_en", 32'(en1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_pass", 32'(pass1), 32'd0);
        chk("rst_err", 32'(err1), 32'd0);
        chk("rst_first", 32'(first1), 32'd0);
        chk("rst_vidx", 32'(vidx1), 32'd0);
        chk("rst3_busy", 32'(busy3), 32'd0);
        chk("rst3_en", 32'(en3), 32'd0);
        rst_n  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        tick();
        chk("idle_busy", 32'(busy1), 32'd0);

        // Golden sweep
        sweep1();
        chk("gold_pass", 32'(pass1), 32'd1);
        chk("gold_err", 32'(err1), 32'd0);
        tick();
        chk("gold_hold_pass", 32'(pass1), 32'd1);
        chk("gold_hold_en", 32'(en1), 32'd0);

        // out[5] stuck at zero
        mode1 = 1;
        sweep1();
        chk("stuck_err", 32'(err1), 32'd1);
        chk("stuck_first", 32'(first1), 32'd5);
        chk("stuck_pass", 32'(pass1), 32'd0);
        chk("stuck_done", 32'(done1), 32'd1);

        // Every vector mismatches: counter saturates
        mode1 = 2;
        sweep1();
        chk("ff_err", 32'(err1), 32'd15);
        chk("ff_first", 32'(first1), 32'd0);
        chk("ff_pass", 32'(pass1), 32'd0);

        // Random fault masks against a counting model
        mode1 = 3;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 16; k++) begin
                mask[k] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            end
            mask[$urandom_range(0, 15)] = 8'($urandom_range(1, 255));
            nerr   = 0;
            firstk = -1;
            for (int k = 0; k < 16; k++) begin
                if (mask[k] != 8'h00) begin
                    nerr++;
                    if (firstk < 0) firstk = k;
                end
            end
            sat = (nerr > 15) ? 4'd15 : 4'(nerr);
            sweep1();
            chk("rnd_err", 32'(err1), 32'(sat));
            chk("rnd_first", 32'(first1), 32'(firstk));
            chk("rnd_pass", 32'(pass1), 32'd0);
        end
        mode1 = 0;
        for (int k = 0; k < 16; k++) mask[k] = 8'h00;

        // Reset mid-sweep at vector 7 with a faulty decoder, then clean sweep
        mode1  = 2;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (7) tick();
        chk("mid_vidx", 32'(vidx1), 32'd7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_busy", 32'(busy1), 32'd0);
        chk("mid_err", 32'(err1), 32'd0);
        chk("mid_first", 32'(first1), 32'd0);
        chk("mid_vidx0", 32'(vidx1), 32'd0);
        chk("mid_en", 32'(en1), 32'd0);
        chk("mid_done", 32'(done1), 32'd0);
        mode1 = 0;
        sweep1();
        chk("mid_gold_pass", 32'(pass1), 32'd1);

        // S=3 with a stuck out[2] and random extra start pulses during RUN
        mode3  = 4;
        start3 = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 3; j++) begin
                chk("s3_en", 32'(en3), 32'(k < 8));
                chk("s3_in", 32'(in3), 32'(k % 8));
                chk("s3_busy", 32'(busy3), 32'd1);
                start3 = 1'($urandom_range(0, 1));
                tick();
            end
        end
        start3 = 1'b0;
        chk("s3_done", 32'(done3), 32'd1);
        chk("s3_err", 32'(err3), 32'd1);
        chk("s3_first", 32'(first3), 32'd2);
        chk("s3_pass", 32'(pass3), 32'd0);

        // Restart from DONE clears the error count and begins at vector 0
        mode3  = 0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("s3_re_err", 32'(err3), 32'd0);
        chk("s3_re_vidx", 32'(vidx3), 32'd0);
        chk("s3_re_busy", 32'(busy3), 32'd1);
        chk("s3_re_en", 32'(en3), 32'd1);
        repeat (47) tick();
        chk("s3_re_busy47", 32'(busy3), 32'd1);
        tick();
        chk("s3_re_done", 32'(done3), 32'd1);
        chk("s3_re_pass", 32'(pass3), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_sweep_checker.md
# decoder_sweep_checker

Self-checking sequencer that drives the 3-to-8 decoder exhaustively and checks its one-hot response. It sits on both sides of the decoder: upstream it generates `in`/`en`, downstream it consumes `out`, compares against the expected code, and reports pass/fail with an error count. It is synthesizable, so it can run as on-chip BIST or be instantiated in the bench in place of hand-written stimulus.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles each vector is held before `i_out` is sampled. Legal range 1..15.
- `ERR_CNT_W`, default 4: width of the mismatch counter.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_start`  in  1  level-sampled start request.
- `o_in`  out  3  drives decoder `in`.
- `o_en`  out  1  drives decoder `en`.
- `i_out`  in  8  decoder `out` response.
- `o_busy`  out  1  high while a sweep is in progress.
- `o_done`  out  1  high in the DONE state.
- `o_pass`  out  1  `o_done` and zero mismatches.
- `o_err_cnt`  out  ERR_CNT_W  mismatch count, saturating.
- `o_first_err_idx`  out  4  vector index of the first mismatch; valid only when `o_err_cnt` != 0.
- `o_vec_idx`  out  4  index of the vector currently driven.

## Operation
- 16 vectors, index v = 0..15:
  - `o_en` = ~v[3] and `o_in` = v[2:0]. Indices 0–7 are enabled, 8–15 disabled.
  - Expected output is (1 << `o_in`) when `o_en` = 1, else 8'h00.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `o_en` = 0, `o_in` = 0.
  - `i_start` = 1 → RUN. Clear `o_err_cnt` and `o_first_err_idx`, set v = 0, drive vector 0, load settle counter with SETTLE_CYCLES−1.
- RUN, settle counter ≠ 0: decrement it; hold the vector.
- RUN, settle counter = 0 (the compare edge):
  - Compare `i_out` with the expected value.
  - On mismatch, increment `o_err_cnt`, saturating at all-ones. If it was 0, capture v into `o_first_err_idx`.
  - If v = 15 → DONE. Otherwise v+1, drive the new vector, and reload the settle counter.
- DONE:
  - `o_en` = 0, `o_in` = 0. `o_done` = 1. `o_pass` = (`o_err_cnt` == 0).
  - Results hold until the next start. `i_start` = 1 restarts exactly as from IDLE.
- `i_start` is ignored in RUN.
- `o_busy` = (state == RUN). `o_pass` = 0 outside DONE.
- Reset mid-sweep: at the reset edge, return to IDLE with all outputs at their reset values. Partial results are discarded.

## Timing
- Reset values: `o_in` = 0, `o_en` = 0, `o_busy` = 0, `o_done` = 0, `o_pass` = 0, `o_err_cnt` = 0, `o_first_err_idx` = 0, `o_vec_idx` = 0. State = IDLE.
- Start latency: `i_start` sampled high at edge s. Vector 0 appears on `o_in`/`o_en` and `o_busy` rises after edge s.
- Vector k is driven after edge s+k·S and sampled at edge s+(k+1)·S, where S = SETTLE_CYCLES. The next vector is driven at the same edge it is sampled.
- The decoder is assumed combinational; S = 1 gives one full cycle of settling.
- Last compare at edge s+16·S. After that edge: `o_busy` = 0, `o_done` = 1, `o_pass` and `o_err_cnt` final.
- If `i_start` is held high continuously, DONE lasts one cycle and the sweep restarts.
- `o_err_cnt` and `o_first_err_idx` update on the compare edge, so they are visible in the following cycle.

## Test plan
- Reset: drive `i_rst_n` = 0 for 3 cycles with `i_start` = 1 → all outputs 0, state IDLE, no vector driven.
- Golden decoder, S = 1, one-cycle `i_start` pulse:
  - `o_busy` high for 16 cycles.
  - `o_en`/`o_in` sequence is 1/000..1/111, then 0/000..0/111.
  - `o_done` = 1 after edge s+16, `o_pass` = 1, `o_err_cnt` = 0.
- Decoder model with `out`[5] stuck-at-0 → `o_err_cnt` = 1, `o_first_err_idx` = 5, `o_pass` = 0, `o_done` = 1.
- `i_out` forced to 8'hFF, ERR_CNT_W = 4 → all 16 vectors mismatch. `o_err_cnt` saturates at 15, `o_first_err_idx` = 0.
- Reset pulsed while `o_vec_idx` = 7:
  - All outputs reset after that edge.
  - A new start with the golden decoder gives a clean 16-vector sweep and `o_pass` = 1.
- S = 3 with extra `i_start` pulses during RUN:
  - Each vector is held for 3 cycles and `o_done` rises after edge s+48.
  - The extra start pulses have no effect.
  - A start in DONE clears `o_err_cnt` and restarts at v = 0.
